// File: rtl/emm_pkg.sv
// Shared types and constants for the emm N-master Wishbone arbiter.
package emm_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Request-side payload of one master, forwarded to the external bus when granted.
  typedef struct packed {
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic             we;
    logic [WB_SW-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/emm_arb_picker.sv
// Combinational winner selection: lowest requesting index (fixed) or first
// requester at or after the round-robin pointer, wrapping (round-robin).
module emm_arb_picker
  import emm_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_rr_ptr,
  input  logic                   i_mode,
  output logic [IDX_W-1:0]       o_winner,
  output logic                   o_valid
);

  // Scan from the farthest candidate down so the nearest requester is written last.
  always_comb begin
    o_winner = '0;
    o_valid  = |i_req;
    for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
      logic [IDX_W-1:0] w_idx;
      if (i_mode == 1'(ARB_RR)) begin
        w_idx = IDX_W'((32'(i_rr_ptr) + 32'(off)) % NUM_MASTERS);
      end else begin
        w_idx = IDX_W'(off);
      end
      if (i_req[w_idx]) begin
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/emm_arbiter.sv
// N-master to 1-slave pipelined Wishbone arbiter with outstanding-request cap
// and ack routing to the currently granted master.
module emm_arbiter
  import emm_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned ARB_MODE        = 0,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_MASTERS*32-1:0]   s_wb_adr_i,
  input  logic [NUM_MASTERS*32-1:0]   s_wb_dat_i,
  output logic [31:0]                 s_wb_dat_o,
  input  logic [NUM_MASTERS-1:0]      s_wb_we_i,
  input  logic [NUM_MASTERS*4-1:0]    s_wb_sel_i,
  input  logic [NUM_MASTERS-1:0]      s_wb_stb_i,
  output logic [NUM_MASTERS-1:0]      s_wb_ack_o,
  input  logic [NUM_MASTERS-1:0]      s_wb_cyc_i,
  output logic [NUM_MASTERS-1:0]      s_wb_stall_o,
  output logic [31:0]                 m_wb_adr_o,
  input  logic [31:0]                 m_wb_dat_i,
  output logic [31:0]                 m_wb_dat_o,
  output logic                        m_wb_we_o,
  output logic [3:0]                  m_wb_sel_o,
  output logic                        m_wb_stb_o,
  input  logic                        m_wb_ack_i,
  output logic                        m_wb_cyc_o,
  input  logic                        m_wb_stall_i
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] w_grant_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_rr_ptr_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [IDX_W-1:0] w_winner;
  logic             w_valid;
  logic             w_active;
  logic             w_full;
  logic             w_accept;
  wb_req_t          w_req [NUM_MASTERS];
  wb_req_t          w_gnt_req;

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_req
    assign w_req[k] = '{adr: s_wb_adr_i[32*k +: 32],
                        dat: s_wb_dat_i[32*k +: 32],
                        we:  s_wb_we_i[k],
                        sel: s_wb_sel_i[4*k +: 4]};
  end

  emm_arb_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .i_req    (s_wb_cyc_i),
    .i_rr_ptr (r_rr_ptr),
    .i_mode   (1'(ARB_MODE)),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  // Bus is driven only while the granted master still holds cyc; dropping it aborts at once.
  assign w_gnt_req  = w_req[r_grant];
  assign w_active   = (r_state == BUSY) && s_wb_cyc_i[r_grant];
  assign w_full     = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_accept   = m_wb_stb_o && !m_wb_stall_i;

  assign m_wb_cyc_o = w_active;
  assign m_wb_stb_o = w_active && s_wb_stb_i[r_grant] && !w_full;
  assign m_wb_adr_o = w_active ? w_gnt_req.adr : '0;
  assign m_wb_dat_o = w_active ? w_gnt_req.dat : '0;
  assign m_wb_we_o  = w_active && w_gnt_req.we;
  assign m_wb_sel_o = w_active ? w_gnt_req.sel : '0;
  assign s_wb_dat_o = m_wb_dat_i;

  always_comb begin
    s_wb_stall_o = '1;
    s_wb_ack_o   = '0;
    if (w_active) begin
      s_wb_stall_o[r_grant] = m_wb_stall_i || w_full;
      s_wb_ack_o[r_grant]   = m_wb_ack_i;
    end
  end

  // Next-state, grant, round-robin pointer and outstanding counter.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    w_count_nxt  = r_count;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_nxt = BUSY;
          w_grant_nxt = w_winner;
          if (ARB_MODE == ARB_RR) begin
            w_rr_ptr_nxt = (w_winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_winner + IDX_W'(1);
          end
        end
      end
      BUSY: begin
        if (!s_wb_cyc_i[r_grant]) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else if (w_accept && !m_wb_ack_i) begin
          w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_accept && m_wb_ack_i && (r_count != '0)) begin
          w_count_nxt = r_count - CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_emm_arbiter.sv
// Bench for emm_arbiter: a 2-master fixed-priority instance (cap 2) and a
// 3-master round-robin instance (cap 4), with a behavioural model for random traffic.
module tb_emm_arbiter;

  localparam int FN   = 2;
  localparam int FMAX = 2;
  localparam int RN   = 3;
  localparam int RMAX = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [FN*32-1:0] fx_adr, fx_dat;
  logic [FN-1:0]    fx_we, fx_stb, fx_cyc, fx_ack, fx_stall;
  logic [FN*4-1:0]  fx_sel;
  logic [31:0]      fx_sdat, fx_madr, fx_mdat_i, fx_mdat_o;
  logic [3:0]       fx_msel;
  logic             fx_mwe, fx_mstb, fx_mack, fx_mcyc, fx_mstall;

  logic [RN*32-1:0] rr_adr, rr_dat;
  logic [RN-1:0]    rr_we, rr_stb, rr_cyc, rr_ack, rr_stall;
  logic [RN*4-1:0]  rr_sel;
  logic [31:0]      rr_sdat, rr_madr, rr_mdat_i, rr_mdat_o;
  logic [3:0]       rr_msel;
  logic             rr_mwe, rr_mstb, rr_mack, rr_mcyc, rr_mstall;

  emm_arbiter #(.NUM_MASTERS(FN), .ARB_MODE(0), .MAX_OUTSTANDING(FMAX)) u_fx (
    .clk_i(clk), .rst_i(rst),
    .s_wb_adr_i(fx_adr), .s_wb_dat_i(fx_dat), .s_wb_dat_o(fx_sdat), .s_wb_we_i(fx_we),
    .s_wb_sel_i(fx_sel), .s_wb_stb_i(fx_stb), .s_wb_ack_o(fx_ack), .s_wb_cyc_i(fx_cyc),
    .s_wb_stall_o(fx_stall), .m_wb_adr_o(fx_madr), .m_wb_dat_i(fx_mdat_i), .m_wb_dat_o(fx_mdat_o),
    .m_wb_we_o(fx_mwe), .m_wb_sel_o(fx_msel), .m_wb_stb_o(fx_mstb), .m_wb_ack_i(fx_mack),
    .m_wb_cyc_o(fx_mcyc), .m_wb_stall_i(fx_mstall)
  );

  emm_arbiter #(.NUM_MASTERS(RN), .ARB_MODE(1), .MAX_OUTSTANDING(RMAX)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .s_wb_adr_i(rr_adr), .s_wb_dat_i(rr_dat), .s_wb_dat_o(rr_sdat), .s_wb_we_i(rr_we),
    .s_wb_sel_i(rr_sel), .s_wb_stb_i(rr_stb), .s_wb_ack_o(rr_ack), .s_wb_cyc_i(rr_cyc),
    .s_wb_stall_o(rr_stall), .m_wb_adr_o(rr_madr), .m_wb_dat_i(rr_mdat_i), .m_wb_dat_o(rr_mdat_o),
    .m_wb_we_o(rr_mwe), .m_wb_sel_o(rr_msel), .m_wb_stb_o(rr_mstb), .m_wb_ack_i(rr_mack),
    .m_wb_cyc_o(rr_mcyc), .m_wb_stall_i(rr_mstall)
  );

  always #5 clk = ~clk;

  task automatic fx_idle();
    fx_adr = '0; fx_dat = '0; fx_we = '0; fx_sel = '0; fx_stb = '0; fx_cyc = '0;
    fx_mdat_i = '0; fx_mack = 1'b0; fx_mstall = 1'b0;
  endtask

  task automatic rr_idle();
    rr_adr = '0; rr_dat = '0; rr_we = '0; rr_sel = '0; rr_stb = '0; rr_cyc = '0;
    rr_mdat_i = '0; rr_mack = 1'b0; rr_mstall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fx_idle();
    rr_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (fx_mcyc !== 1'b0 || fx_mstb !== 1'b0) begin
        n_errors++; $display("FAIL reset_fx_cyc_stb: got %b%b expected 00", fx_mcyc, fx_mstb);
      end
      n_checks++;
      if (fx_stall !== 2'b11 || fx_ack !== 2'b00) begin
        n_errors++; $display("FAIL reset_fx_stall_ack: got %b/%b expected 11/00", fx_stall, fx_ack);
      end
      n_checks++;
      if (fx_madr !== 32'h0 || fx_mdat_o !== 32'h0 || fx_msel !== 4'h0 || fx_mwe !== 1'b0) begin
        n_errors++; $display("FAIL reset_fx_bus: got %h %h %h %b expected zeros", fx_madr, fx_mdat_o, fx_msel, fx_mwe);
      end
      n_checks++;
      if (rr_mcyc !== 1'b0 || rr_stall !== 3'b111 || rr_ack !== 3'b000) begin
        n_errors++; $display("FAIL reset_rr: got cyc=%b stall=%b ack=%b expected 0/111/000", rr_mcyc, rr_stall, rr_ack);
      end
    end
  endtask

  task automatic test_fixed_priority();
    logic [31:0] a0, a1, d;
    a0 = $urandom; a1 = $urandom; d = $urandom;
    @(negedge clk);
    fx_adr = {a1, a0}; fx_cyc = 2'b11; fx_mdat_i = d;
    #1;
    n_checks++;
    if (fx_mcyc !== 1'b0) begin n_errors++; $display("FAIL fp_arb_latency: got cyc=%b expected 0", fx_mcyc); end
    n_checks++;
    if (fx_sdat !== d) begin n_errors++; $display("FAIL fp_rdata: got %h expected %h", fx_sdat, d); end
    @(negedge clk);
    #1;
    n_checks++;
    if (fx_mcyc !== 1'b1 || fx_madr !== a0 || fx_stall !== 2'b10) begin
      n_errors++; $display("FAIL fp_grant0: got cyc=%b adr=%h stall=%b expected 1/%h/10", fx_mcyc, fx_madr, fx_stall, a0);
    end
    @(negedge clk);
    fx_cyc = 2'b10;
    #1;
    n_checks++;
    if (fx_mcyc !== 1'b0 || fx_stall !== 2'b11) begin
      n_errors++; $display("FAIL fp_release: got cyc=%b stall=%b expected 0/11", fx_mcyc, fx_stall);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (fx_mcyc !== 1'b0 || fx_stall !== 2'b11) begin
      n_errors++; $display("FAIL fp_idle_gap: got cyc=%b stall=%b expected 0/11", fx_mcyc, fx_stall);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (fx_mcyc !== 1'b1 || fx_madr !== a1 || fx_stall !== 2'b01) begin
      n_errors++; $display("FAIL fp_grant1: got cyc=%b adr=%h stall=%b expected 1/%h/01", fx_mcyc, fx_madr, fx_stall, a1);
    end
    @(negedge clk);
    fx_idle();
    @(negedge clk);
  endtask

  task automatic test_rr_order();
    int          exp_seq [4];
    logic [31:0] a [RN];
    exp_seq = '{0, 1, 2, 0};
    for (int k = 0; k < RN; k++) a[k] = $urandom;
    rr_adr = {a[2], a[1], a[0]};
    rr_stb = 3'b111;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      rr_cyc = 3'b111;
      #1;
      n_checks++;
      if (rr_mcyc !== 1'b0) begin n_errors++; $display("FAIL rr_idle_gap round %0d: got cyc=%b expected 0", r, rr_mcyc); end
      @(negedge clk);
      #1;
      n_checks++;
      if (rr_mcyc !== 1'b1 || rr_madr !== a[exp_seq[r]] || rr_mstb !== 1'b1) begin
        n_errors++;
        $display("FAIL rr_order round %0d: got cyc=%b stb=%b adr=%h expected 1/1/%h (master %0d)",
                 r, rr_mcyc, rr_mstb, rr_madr, a[exp_seq[r]], exp_seq[r]);
      end
      @(negedge clk);
      rr_cyc[exp_seq[r]] = 1'b0;
      #1;
      n_checks++;
      if (rr_mcyc !== 1'b0) begin n_errors++; $display("FAIL rr_release round %0d: got cyc=%b expected 0", r, rr_mcyc); end
    end
    @(negedge clk);
    rr_idle();
    @(negedge clk);
  endtask

  task automatic test_max_outstanding();
    int   sent = 0;
    int   acked = 0;
    int   t = 0;
    int   due [$];
    logic exp_stb;
    logic exp_st0;
    @(negedge clk);
    fx_cyc = 2'b01; fx_stb = 2'b00; fx_adr = {32'h0, $urandom};
    #1;
    n_checks++;
    if (fx_mcyc !== 1'b0) begin n_errors++; $display("FAIL mo_idle: got cyc=%b expected 0", fx_mcyc); end
    while (acked < 4 && t < 40) begin
      @(negedge clk);
      t++;
      fx_mack = (due.size() > 0) && (due[0] == t);
      if (fx_mack) void'(due.pop_front());
      fx_stb[0] = (sent < 4);
      #1;
      exp_stb = (sent < 4) && (sent - acked < FMAX);
      exp_st0 = (sent - acked >= FMAX);
      n_checks++;
      if (fx_mstb !== exp_stb) begin n_errors++; $display("FAIL mo_stb t=%0d: got %b expected %b", t, fx_mstb, exp_stb); end
      n_checks++;
      if (fx_stall !== {1'b1, exp_st0}) begin
        n_errors++; $display("FAIL mo_stall t=%0d: got %b expected %b", t, fx_stall, {1'b1, exp_st0});
      end
      if (t == 6) begin
        n_checks++;
        if (sent !== 2) begin n_errors++; $display("FAIL mo_accepted_before_ack: got %0d expected 2", sent); end
      end
      if (fx_mstb && !fx_mstall) begin
        sent++;
        due.push_back(t + 5);
      end
      if (fx_mack) acked++;
      n_checks++;
      if (sent - acked > FMAX) begin n_errors++; $display("FAIL mo_cap t=%0d: got %0d outstanding expected <= %0d", t, sent - acked, FMAX); end
    end
    n_checks++;
    if (acked !== 4) begin n_errors++; $display("FAIL mo_timeout: got %0d acks expected 4", acked); end
    @(negedge clk);
    fx_idle();
    @(negedge clk);
  endtask

  task automatic test_ack_accept_same();
    logic [10:0] v_cyc, v_stb, v_ack, v_mstb;
    v_cyc  = 11'b11111011111;
    v_stb  = 11'b11100011110;
    v_ack  = 11'b00010000100;
    v_mstb = 11'b01100001110;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      fx_cyc[0] = v_cyc[i]; fx_stb[0] = v_stb[i]; fx_mack = v_ack[i];
      #1;
      n_checks++;
      if (fx_mstb !== v_mstb[i]) begin n_errors++; $display("FAIL aa_stb c%0d: got %b expected %b", i, fx_mstb, v_mstb[i]); end
      n_checks++;
      if (fx_ack !== {1'b0, v_ack[i]}) begin
        n_errors++; $display("FAIL aa_ack c%0d: got %b expected %b", i, fx_ack, {1'b0, v_ack[i]});
      end
    end
    @(negedge clk);
    fx_idle();
    @(negedge clk);
  endtask

  task automatic test_release_drop();
    logic [8:0] v_cyc, v_stb, v_ack, v_mcyc, v_mstb;
    v_cyc  = 9'b111100111;
    v_stb  = 9'b111101110;
    v_ack  = 9'b000111000;
    v_mcyc = 9'b111000110;
    v_mstb = 9'b011000110;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      fx_cyc[0] = v_cyc[i]; fx_stb[0] = v_stb[i]; fx_mack = v_ack[i];
      #1;
      n_checks++;
      if (fx_mcyc !== v_mcyc[i] || fx_mstb !== v_mstb[i]) begin
        n_errors++; $display("FAIL rd_cyc_stb c%0d: got %b%b expected %b%b", i, fx_mcyc, fx_mstb, v_mcyc[i], v_mstb[i]);
      end
      n_checks++;
      if (fx_ack !== 2'b00) begin n_errors++; $display("FAIL rd_ack c%0d: got %b expected 00", i, fx_ack); end
    end
    @(negedge clk);
    fx_idle();
    @(negedge clk);
  endtask

  task automatic test_random();
    int          own = -1;
    int          cnt = 0;
    int          ptr = 0;
    logic        held, e_cyc, e_stb, e_we;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic [2:0]  e_stall, e_ack;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst = (i == 0) || ($urandom_range(0, 79) == 0);
      for (int k = 0; k < RN; k++) begin
        if (rr_cyc[k]) begin
          if ($urandom_range(0, 7) == 0) rr_cyc[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          rr_cyc[k] = 1'b1;
        end
      end
      rr_stb    = 3'($urandom);
      rr_adr    = {$urandom, $urandom, $urandom};
      rr_dat    = {$urandom, $urandom, $urandom};
      rr_we     = 3'($urandom);
      rr_sel    = 12'($urandom);
      rr_mdat_i = $urandom;
      rr_mstall = ($urandom_range(0, 3) == 0);
      rr_mack   = (cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      #1;
      held    = (own >= 0) ? rr_cyc[own] : 1'b0;
      e_cyc   = held;
      e_stb   = held && rr_stb[own] && (cnt < RMAX);
      e_adr   = held ? rr_adr[32*own +: 32] : 32'h0;
      e_dat   = held ? rr_dat[32*own +: 32] : 32'h0;
      e_we    = held && rr_we[own];
      e_sel   = held ? rr_sel[4*own +: 4] : 4'h0;
      e_stall = 3'b111;
      e_ack   = 3'b000;
      if (held) begin
        e_stall[own] = rr_mstall || (cnt == RMAX);
        e_ack[own]   = rr_mack;
      end
      n_checks++;
      if (rr_mcyc !== e_cyc || rr_mstb !== e_stb) begin
        n_errors++; $display("FAIL rnd_cyc_stb i=%0d: got %b%b expected %b%b", i, rr_mcyc, rr_mstb, e_cyc, e_stb);
      end
      n_checks++;
      if (rr_madr !== e_adr || rr_mdat_o !== e_dat || rr_mwe !== e_we || rr_msel !== e_sel) begin
        n_errors++;
        $display("FAIL rnd_bus i=%0d: got %h %h %b %h expected %h %h %b %h",
                 i, rr_madr, rr_mdat_o, rr_mwe, rr_msel, e_adr, e_dat, e_we, e_sel);
      end
      n_checks++;
      if (rr_stall !== e_stall) begin n_errors++; $display("FAIL rnd_stall i=%0d: got %b expected %b", i, rr_stall, e_stall); end
      n_checks++;
      if (rr_ack !== e_ack) begin n_errors++; $display("FAIL rnd_ack i=%0d: got %b expected %b", i, rr_ack, e_ack); end
      n_checks++;
      if (rr_sdat !== rr_mdat_i) begin n_errors++; $display("FAIL rnd_rdata i=%0d: got %h expected %h", i, rr_sdat, rr_mdat_i); end
      // Advance the reference model by one clock.
      if (rst) begin
        own = -1; cnt = 0; ptr = 0;
      end else if (own < 0) begin
        for (int s = 0; s < RN; s++) begin
          if (own < 0 && rr_cyc[(ptr + s) % RN]) own = (ptr + s) % RN;
        end
        if (own >= 0) ptr = (own + 1) % RN;
      end else if (!held) begin
        own = -1; cnt = 0;
      end else begin
        cnt = cnt + int'(e_stb && !rr_mstall) - int'(rr_mack);
        if (cnt < 0) cnt = 0;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    rr_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fixed_priority();
    test_rr_order();
    test_max_outstanding();
    test_ack_accept_same();
    test_release_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
